// File: rtl/alu_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU function codes,
// FSM state encoding and op-class helpers.
package alu_hilo_unit_pkg;

  typedef enum logic [4:0] {
    Alu_Func_Add,
    Alu_Func_Sub,
    Alu_Func_And,
    Alu_Func_Or,
    Alu_Func_Xor,
    Alu_Func_Nor,
    Alu_Func_Slt,
    Alu_Func_Sltu,
    Alu_Func_Sll,
    Alu_Func_Srl,
    Alu_Func_Sra,
    Alu_Func_Muls,
    Alu_Func_Mulu,
    Alu_Func_Divs,
    Alu_Func_Divu,
    Alu_Func_Mtlo,
    Alu_Func_Mthi,
    Alu_Func_Mflo,
    Alu_Func_Mfhi
  } Alu_Func_T;

  typedef enum logic [1:0] {
    Hilo_State_Idle = 2'd0,
    Hilo_State_Calc = 2'd1,
    Hilo_State_Fix  = 2'd2
  } hilo_state_t;

  function automatic int Util_Math_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic is_mul(input Alu_Func_T f);
    return (f == Alu_Func_Muls) || (f == Alu_Func_Mulu);
  endfunction

  function automatic logic is_div(input Alu_Func_T f);
    return (f == Alu_Func_Divs) || (f == Alu_Func_Divu);
  endfunction

  function automatic logic is_signed(input Alu_Func_T f);
    return (f == Alu_Func_Muls) || (f == Alu_Func_Divs);
  endfunction

  function automatic logic is_hilo(input Alu_Func_T f);
    return is_mul(f) || is_div(f) ||
           (f == Alu_Func_Mtlo) || (f == Alu_Func_Mthi) ||
           (f == Alu_Func_Mflo) || (f == Alu_Func_Mfhi);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply, restoring divide, and the
// two's-complement sign fixup presented combinationally on res_hi/res_lo.
module alu_muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op_div,
  input  logic              op_signed,
  input  logic              step,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic                div_q, div_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_r_q, neg_r_d;

  logic                sign1, sign2;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W-1:0]   acc_hi, acc_lo;
  logic [DATA_W:0]     sum, rem_sh, diff;
  logic [2*DATA_W-1:0] prod_fix;

  assign acc_hi = acc_q[2*DATA_W-1:DATA_W];
  assign acc_lo = acc_q[DATA_W-1:0];

  always_comb begin
    sign1  = op_signed & data1[DATA_W-1];
    sign2  = op_signed & data2[DATA_W-1];
    abs1   = sign1 ? (~data1 + 1'b1) : data1;
    abs2   = sign2 ? (~data2 + 1'b1) : data2;
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {acc_hi, acc_lo[DATA_W-1]};
    diff   = rem_sh - {1'b0, opnd_q};

    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_a_d = neg_a_q;
    neg_r_d = neg_r_q;

    if (start) begin
      div_d   = op_div;
      neg_a_d = sign1 ^ sign2;
      neg_r_d = op_div & sign1;
      if (op_div && (data2 == '0)) begin
        // Divide by zero skips iteration: raw dividend in HI, all-ones in LO.
        acc_d   = {data1, {DATA_W{1'b1}}};
        opnd_d  = '0;
        neg_a_d = 1'b0;
        neg_r_d = 1'b0;
      end else if (op_div) begin
        acc_d  = {{DATA_W{1'b0}}, abs1};
        opnd_d = abs2;
      end else begin
        acc_d  = {{DATA_W{1'b0}}, abs2};
        opnd_d = abs1;
      end
    end else if (step) begin
      if (div_q) begin
        if (!diff[DATA_W]) acc_d = {diff[DATA_W-1:0], acc_lo[DATA_W-2:0], 1'b1};
        else               acc_d = {rem_sh[DATA_W-1:0], acc_lo[DATA_W-2:0], 1'b0};
      end else begin
        acc_d = {sum, acc_lo[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_a_q <= neg_a_d;
      neg_r_q <= neg_r_d;
    end
  end

  always_comb begin
    prod_fix = neg_a_q ? (~acc_q + 1'b1) : acc_q;
    if (div_q) begin
      res_hi = neg_r_q ? (~acc_hi + 1'b1) : acc_hi;
      res_lo = neg_a_q ? (~acc_lo + 1'b1) : acc_lo;
    end else begin
      res_hi = prod_fix[2*DATA_W-1:DATA_W];
      res_lo = prod_fix[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/alu_hilo_unit.sv
// HI/LO register owner for the EX stage: runs iterative mul/div and stalls
// any HI/LO instruction that arrives while an operation is in flight.
module alu_hilo_unit
  import alu_hilo_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = Util_Math_log2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  Alu_Func_T         func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] reg_hi,
  output logic              busy,
  output logic              stall,
  output hilo_state_t       state_dbg
);

  hilo_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;

  logic              hilo_req, accept, start_muldiv, iter_step;
  logic [DATA_W-1:0] res_hi, res_lo;

  // Handshake: the EX instruction is taken on a rising edge when valid is
  // high and stall is low; a stalled instruction is held unchanged upstream.
  assign hilo_req     = valid && is_hilo(func);
  assign busy         = (state_q != Hilo_State_Idle);
  assign stall        = hilo_req && busy;
  assign accept       = hilo_req && !busy;
  assign start_muldiv = accept && (is_mul(func) || is_div(func));
  assign iter_step    = (state_q == Hilo_State_Calc);

  assign reg_lo    = lo_q;
  assign reg_hi    = hi_q;
  assign state_dbg = state_q;

  alu_muldiv_iter #(.DATA_W(DATA_W)) u_iter (
    .clock     (clock),
    .reset     (reset),
    .start     (start_muldiv),
    .op_div    (is_div(func)),
    .op_signed (is_signed(func)),
    .step      (iter_step),
    .data1     (data1),
    .data2     (data2),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= Hilo_State_Idle;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      Hilo_State_Idle: begin
        if (start_muldiv) begin
          cnt_d = CNT_W'(DATA_W);
          if (is_div(func) && (data2 == '0)) state_d = Hilo_State_Fix;
          else                               state_d = Hilo_State_Calc;
        end
      end
      Hilo_State_Calc: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = Hilo_State_Fix;
      end
      Hilo_State_Fix:  state_d = Hilo_State_Idle;
      default:         state_d = Hilo_State_Idle;
    endcase
  end

  // Moves only happen from IDLE, so they can never collide with the FIX write.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (accept && (func == Alu_Func_Mtlo)) lo_d = data1;
    if (accept && (func == Alu_Func_Mthi)) hi_d = data1;
    if (state_q == Hilo_State_Fix) begin
      lo_d = res_lo;
      hi_d = res_hi;
    end
  end

endmodule

// File: tb/tb_alu_hilo_unit.sv
// Directed plus randomized checks of alu_hilo_unit against an arithmetic
// reference model of HI/LO results, latency and stall behaviour.
module tb_alu_hilo_unit;
  import alu_hilo_unit_pkg::*;

  localparam int W = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  Alu_Func_T   func;
  logic [W-1:0] data1, data2, reg_lo, reg_hi;
  logic        busy, stall;
  hilo_state_t state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] m_hi = '0;

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  alu_hilo_unit #(.DATA_W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .func      (func),
    .data1     (data1),
    .data2     (data2),
    .reg_lo    (reg_lo),
    .reg_hi    (reg_hi),
    .busy      (busy),
    .stall     (stall),
    .state_dbg (state_dbg)
  );

  // Reference model: HI/LO result as {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_hilo(input Alu_Func_T f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      Alu_Func_Mulu: p = {32'b0, a} * {32'b0, b};
      Alu_Func_Muls: p = 64'(sa * sb);
      Alu_Func_Divu: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      Alu_Func_Divs: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    valid = 1'b0;
    func  = Alu_Func_Add;
    data1 = '0;
    data2 = '0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    m_lo = '0;
    m_hi = '0;
    exp_q.delete();
  endtask

  // Presents an instruction at a negedge and holds it until accepted; returns
  // at the negedge after the accepting edge with inputs idle.
  task automatic present(input Alu_Func_T f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int stalled);
    logic [63:0] r;
    stalled = 0;
    if (is_mul(f) || is_div(f)) begin
      r = ref_hilo(f, a, b);
      exp_q.push_back(r[63:32]);
      exp_q.push_back(r[31:0]);
    end
    valid = 1'b1;
    func  = f;
    data1 = a;
    data2 = b;
    #1;
    while (stall && stalled < 200) begin
      @(negedge clock);
      #1;
      stalled++;
    end
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
  endtask

  // Counts busy cycles from the negedge after accept, then scores HI/LO.
  task automatic wait_done(input string tag, input int exp_busy);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_busy_cycles"}, n, exp_busy);
    m_hi = exp_q.pop_front();
    m_lo = exp_q.pop_front();
    check({tag, "_hi"}, reg_hi, m_hi);
    check({tag, "_lo"}, reg_lo, m_lo);
  endtask

  task automatic run_op(input string tag, input Alu_Func_T f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int s;
    present(f, a, b, s);
    check({tag, "_stalled"}, s, 0);
    if (is_mul(f) || is_div(f)) begin
      wait_done(tag, (is_div(f) && b == 0) ? 1 : W + 1);
    end else begin
      if (f == Alu_Func_Mtlo) m_lo = a;
      if (f == Alu_Func_Mthi) m_hi = a;
      check({tag, "_busy"}, busy, 0);
      check({tag, "_hi"}, reg_hi, m_hi);
      check({tag, "_lo"}, reg_lo, m_lo);
    end
  endtask

  function automatic logic [W-1:0] pick_operand(input int kind);
    case (kind)
      0: return W'($urandom);
      1: return W'($urandom_range(0, 20));
      2: return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return '0;
    endcase
  endfunction

  initial begin
    int s;
    Alu_Func_T f;
    Alu_Func_T rand_ops[6];
    logic [W-1:0] a, b;

    rand_ops[0] = Alu_Func_Muls;
    rand_ops[1] = Alu_Func_Mulu;
    rand_ops[2] = Alu_Func_Divs;
    rand_ops[3] = Alu_Func_Divu;
    rand_ops[4] = Alu_Func_Mtlo;
    rand_ops[5] = Alu_Func_Mthi;

    reset = 1'b1;
    idle_inputs();
    do_reset(3);

    check("reset_lo", reg_lo, 0);
    check("reset_hi", reg_hi, 0);
    check("reset_busy", busy, 0);
    check("reset_stall", stall, 0);
    check("reset_state", state_dbg, Hilo_State_Idle);

    run_op("mtlo_idle", Alu_Func_Mtlo, 32'hA5A5_A5A5, 32'h0);
    check("mtlo_const", reg_lo, 32'hA5A5_A5A5);
    run_op("mthi_idle", Alu_Func_Mthi, 32'h0BAD_F00D, 32'h0);
    run_op("mflo_idle", Alu_Func_Mflo, 32'h1234_5678, 32'h0);

    run_op("mulu_max", Alu_Func_Mulu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulu_max_hi_const", reg_hi, 32'hFFFF_FFFE);
    check("mulu_max_lo_const", reg_lo, 32'h0000_0001);
    run_op("muls_neg3x5", Alu_Func_Muls, 32'hFFFF_FFFD, 32'd5);
    check("muls_hi_const", reg_hi, 32'hFFFF_FFFF);
    check("muls_lo_const", reg_lo, 32'hFFFF_FFF1);
    run_op("divs_neg7_2", Alu_Func_Divs, 32'hFFFF_FFF9, 32'd2);
    check("divs_lo_const", reg_lo, 32'hFFFF_FFFD);
    run_op("divu_by0", Alu_Func_Divu, 32'h1234, 32'h0);
    check("divu_by0_lo_const", reg_lo, 32'hFFFF_FFFF);
    run_op("divs_by0_neg", Alu_Func_Divs, 32'h8765_4321, 32'h0);
    run_op("divs_minneg", Alu_Func_Divs, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divs_minneg_lo_const", reg_lo, 32'h8000_0000);

    // Mfhi arriving mid-multiply stalls until busy falls.
    present(Alu_Func_Mulu, 32'hDEAD_BEEF, 32'h1234_5679, s);
    @(negedge clock);
    valid = 1'b1;
    func  = Alu_Func_Add;
    #1;
    check("nonhilo_busy_stall", stall, 0);
    @(negedge clock);
    func = Alu_Func_Mfhi;
    #1;
    check("mfhi_stall_asserted", stall, 1);
    s = 0;
    while (stall && s < 200) begin
      s++;
      @(negedge clock);
      #1;
    end
    check("mfhi_stall_cycles", s, W - 1);
    check("mfhi_release_busy", busy, 0);
    m_hi = exp_q.pop_front();
    m_lo = exp_q.pop_front();
    check("mfhi_release_hi", reg_hi, m_hi);
    check("mfhi_release_lo", reg_lo, m_lo);
    @(posedge clock);
    @(negedge clock);
    idle_inputs();

    // Mthi while dividing is held off and lands after the quotient write.
    present(Alu_Func_Divu, 32'd1000, 32'd7, s);
    present(Alu_Func_Mthi, 32'hCAFE_0001, 32'h0, s);
    check("mthi_busy_stalled", s, W + 1);
    void'(exp_q.pop_front());
    m_lo = exp_q.pop_front();
    m_hi = 32'hCAFE_0001;
    check("mthi_busy_hi", reg_hi, m_hi);
    check("mthi_busy_lo", reg_lo, m_lo);
    check("mthi_busy_lo_const", reg_lo, 32'd142);

    // Reset mid-CALC aborts without touching HI/LO.
    present(Alu_Func_Divu, 32'd100, 32'd7, s);
    repeat (10) @(negedge clock);
    check("midop_state_calc", state_dbg, Hilo_State_Calc);
    do_reset(1);
    check("midop_reset_busy", busy, 0);
    check("midop_reset_lo", reg_lo, 0);
    check("midop_reset_hi", reg_hi, 0);
    check("midop_reset_state", state_dbg, Hilo_State_Idle);
    run_op("divu_after_reset", Alu_Func_Divu, 32'd100, 32'd7);
    check("divu_100_7_lo_const", reg_lo, 32'd14);
    check("divu_100_7_hi_const", reg_hi, 32'd2);

    for (int i = 0; i < 24; i++) begin
      f = rand_ops[$urandom_range(0, 5)];
      a = pick_operand($urandom_range(0, 3));
      b = pick_operand($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), f, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
